// File: rtl/loopback_checker.sv
// Checks an incrementing-counter byte stream returned through the HPIO loopback path.
// Searches for the bit rotation that aligns it, locks, then counts bad and checked words.
module loopback_checker #(
   parameter int LOCK_CNT = 8,
   parameter int LOSS_CNT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  data_in,
   input  logic        data_valid,
   input  logic        clr_cnt,
   output logic        locked,
   output logic [1:0]  state,
   output logic [2:0]  rotation,
   output logic        err_flag,
   output logic [15:0] err_cnt,
   output logic [31:0] word_cnt
);

   localparam int RunW  = $clog2(LOCK_CNT + 1);
   localparam int MissW = $clog2(LOSS_CNT + 1);

   typedef enum logic [1:0] {
      Search = 2'd0,
      Verify = 2'd1,
      Locked = 2'd2
   } stateT;

   stateT             state_q, state_d;
   logic [2:0]        rotation_q, rotation_d;
   logic [7:0]        prevWord_q, prevWord_d;
   logic              prevValid_q, prevValid_d;
   logic [RunW-1:0]   run_q, run_d;
   logic [MissW-1:0]  missRun_q, missRun_d;
   logic [7:0]        expWord_q, expWord_d;
   logic              errFlag_q, errFlag_d;
   logic [15:0]       errCnt_q, errCnt_d;
   logic [31:0]       wordCnt_q, wordCnt_d;

   logic [7:0]        rotWord;
   logic [7:0]        prevRot;
   logic              seqMatch;
   logic              lockMatch;
   logic [RunW-1:0]   runInc;
   logic [MissW-1:0]  missInc;

   function automatic logic [7:0] rotl8(input logic [7:0] v, input logic [2:0] amt);
      logic [15:0] dbl;
      dbl = {v, v} << amt;
      return dbl[15:8];
   endfunction

   assign rotWord   = rotl8(data_in, rotation_q);
   assign prevRot   = rotl8(prevWord_q, rotation_q);
   assign seqMatch  = (rotWord == prevRot + 8'd1);
   assign lockMatch = (rotWord == expWord_q);
   assign runInc    = run_q + 1'b1;
   assign missInc   = missRun_q + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= Search;
         rotation_q  <= 3'd0;
         prevWord_q  <= 8'd0;
         prevValid_q <= 1'b0;
         run_q       <= '0;
         missRun_q   <= '0;
         expWord_q   <= 8'd0;
         errFlag_q   <= 1'b0;
         errCnt_q    <= 16'd0;
         wordCnt_q   <= 32'd0;
      end else begin
         state_q     <= state_d;
         rotation_q  <= rotation_d;
         prevWord_q  <= prevWord_d;
         prevValid_q <= prevValid_d;
         run_q       <= run_d;
         missRun_q   <= missRun_d;
         expWord_q   <= expWord_d;
         errFlag_q   <= errFlag_d;
         errCnt_q    <= errCnt_d;
         wordCnt_q   <= wordCnt_d;
      end
   end

   // Once locked, words are checked against a free-running expected value so one bad word costs one error.
   always_comb begin
      state_d     = state_q;
      rotation_d  = rotation_q;
      prevWord_d  = prevWord_q;
      prevValid_d = prevValid_q;
      run_d       = run_q;
      missRun_d   = missRun_q;
      expWord_d   = expWord_q;
      errFlag_d   = 1'b0;
      errCnt_d    = errCnt_q;
      wordCnt_d   = wordCnt_q;
      if (data_valid) begin
         prevWord_d  = data_in;
         prevValid_d = 1'b1;
         if (prevValid_q) begin
            case (state_q)
               Search: begin
                  if (seqMatch) begin
                     state_d = Verify;
                     run_d   = RunW'(1);
                  end else begin
                     rotation_d = rotation_q + 3'd1;
                  end
               end
               Verify: begin
                  if (seqMatch) begin
                     run_d = runInc;
                     if (runInc == RunW'(LOCK_CNT)) begin
                        state_d   = Locked;
                        expWord_d = rotWord + 8'd1;
                        missRun_d = '0;
                     end
                  end else begin
                     state_d    = Search;
                     run_d      = '0;
                     rotation_d = rotation_q + 3'd1;
                  end
               end
               Locked: begin
                  expWord_d = expWord_q + 8'd1;
                  wordCnt_d = wordCnt_q + 32'd1;
                  if (lockMatch) begin
                     missRun_d = '0;
                  end else begin
                     missRun_d = missInc;
                     errFlag_d = 1'b1;
                     if (errCnt_q != 16'hFFFF) begin
                        errCnt_d = errCnt_q + 16'd1;
                     end
                     if (missInc == MissW'(LOSS_CNT)) begin
                        state_d   = Search;
                        run_d     = '0;
                        missRun_d = '0;
                     end
                  end
               end
               default: state_d = Search;
            endcase
         end
      end
      if (clr_cnt) begin
         errCnt_d  = 16'd0;
         wordCnt_d = 32'd0;
      end
   end

   always_comb begin
      locked   = (state_q == Locked);
      state    = state_q;
      rotation = rotation_q;
      err_flag = errFlag_q;
      err_cnt  = errCnt_q;
      word_cnt = wordCnt_q;
   end

endmodule
